// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle controller: state codes, opcode and
// funct encodings, ALU operation codes and datapath mux select codes.
package mc_ctrl_pkg;

    // Controller states; the numeric code is what state_out reports.
    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_LW    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EX_R     = 4'd6,
        S_WB_R     = 4'd7,
        S_EX_I     = 4'd8,
        S_WB_I     = 4'd9,
        S_EX_BEQ   = 4'd10,
        S_EX_J     = 4'd11,
        S_ERROR    = 4'd12
    } state_t;

    // Opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (inst[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // ALU_Control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PCSource selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for the six R-type functions this controller supports.
    function automatic logic is_rtype_funct(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_NOR);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle. Handshake: MIO_ready=1 means the memory
// access requested this cycle (MemRead/MemWrite) completes in this cycle; the
// controller holds its request unchanged every cycle MIO_ready is 0.
interface mc_ctrl_if;
    logic [31:0] inst;
    logic        zero;
    logic        MIO_ready;

    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic [2:0]  ALU_Control;
    logic        pc_en;
    logic        CPU_MIO;
    logic        err;
    logic [3:0]  state_out;

    // Controller side
    modport master (
        input  inst, zero, MIO_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
               ALU_Control, pc_en, CPU_MIO, err, state_out
    );

    // Datapath / memory side
    modport slave (
        output inst, zero, MIO_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
               ALU_Control, pc_en, CPU_MIO, err, state_out
    );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU operation decode: fetch/decode/address states always add, R-type
// execute follows funct, I-type execute follows op, beq subtracts.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Pure combinational map from (state, op, funct) to ALU_Control.
    always_comb begin
        alu_control = ALU_AND;
        case (state)
            S_IF, S_ID, S_MEM_ADDR: alu_control = ALU_ADD;
            S_EX_R: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    FN_NOR:  alu_control = ALU_NOR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_EX_I:   alu_control = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            S_EX_BEQ: alu_control = ALU_SUB;
            default:  alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: state register, next-state decode and
// Moore-style output decode (IF strobes additionally gated by MIO_ready).
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);

    state_t     state_q;
    state_t     state_cur;
    state_t     state_nxt;
    logic [5:0] op;
    logic [5:0] funct;
    logic [2:0] alu_ctl;
    logic       unused_inst_bits;

    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       err_flag;

    assign op               = bus.inst[31:26];
    assign funct            = bus.inst[5:0];
    assign unused_inst_bits = ^bus.inst[25:6];

    // While rst is high the block already presents the IF decode, so no
    // stale strobe (e.g. MemWrite from a stalled store) escapes during reset.
    assign state_cur = rst ? S_IF : state_q;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_nxt;
    end

    // Next-state decode; inst is only consulted in ID and the execute states.
    always_comb begin
        state_nxt = state_cur;
        case (state_cur)
            S_IF:       state_nxt = bus.MIO_ready ? S_ID : S_IF;
            S_ID: begin
                case (op)
                    OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
                    OP_RTYPE:         state_nxt = is_rtype_funct(funct) ? S_EX_R : S_ERROR;
                    OP_ADDI, OP_SLTI: state_nxt = S_EX_I;
                    OP_BEQ:           state_nxt = S_EX_BEQ;
                    OP_J:             state_nxt = S_EX_J;
                    default:          state_nxt = S_ERROR;
                endcase
            end
            S_MEM_ADDR: state_nxt = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_nxt = bus.MIO_ready ? S_WB_LW : S_MEM_RD;
            S_WB_LW:    state_nxt = S_IF;
            S_MEM_WR:   state_nxt = bus.MIO_ready ? S_IF : S_MEM_WR;
            S_EX_R:     state_nxt = S_WB_R;
            S_WB_R:     state_nxt = S_IF;
            S_EX_I:     state_nxt = S_WB_I;
            S_WB_I:     state_nxt = S_IF;
            S_EX_BEQ:   state_nxt = S_IF;
            S_EX_J:     state_nxt = S_IF;
            S_ERROR:    state_nxt = S_ERROR;
            default:    state_nxt = S_ERROR;
        endcase
    end

    // Output decode from the current state; everything not named is 0.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        memto_reg     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        err_flag      = 1'b0;
        case (state_cur)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = bus.MIO_ready;
                pc_write  = bus.MIO_ready;
            end
            S_ID: alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_WB_LW: begin
                memto_reg = 1'b1;
                reg_write = 1'b1;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EX_R: alu_src_a = 1'b1;
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_WB_I: reg_write = 1'b1;
            S_EX_BEQ: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_EX_J: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_ERROR: err_flag = 1'b1;
            default: err_flag = 1'b1;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .state       (state_cur),
        .op          (op),
        .funct       (funct),
        .alu_control (alu_ctl)
    );

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = iord;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.RegWrite    = reg_write;
    assign bus.RegDst      = reg_dst;
    assign bus.MemtoReg    = memto_reg;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.PCSource    = pc_source;
    assign bus.ALU_Control = alu_ctl;
    assign bus.pc_en       = pc_write | (pc_write_cond & bus.zero);
    assign bus.CPU_MIO     = mem_read | mem_write;
    assign bus.err         = err_flag;
    assign bus.state_out   = state_cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction cycle sequences are expanded from the
// instruction class into expected output vectors, then replayed cycle by cycle.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic        ready;
        logic        zero;
        logic        rst;
        logic [23:0] exp;
        string       name;
    } step_t;

    step_t       stim_q[$];
    logic [23:0] exp_q[$];
    string       name_q[$];

    // Expected vector layout:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,RegDst,
    //  MemtoReg,ALUSrcA,ALUSrcB[1:0],PCSource[1:0],ALU_Control[2:0],
    //  pc_en,CPU_MIO,err,state_out[3:0]}
    function automatic logic [23:0] e(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic rw, input logic rd,
        input logic mtr, input logic asa, input logic [1:0] asb,
        input logic [1:0] pcs, input logic [2:0] alu, input logic z,
        input logic er, input logic [3:0] st);
        return {pcw, pcwc, iord, mr, mw, irw, rw, rd, mtr, asa, asb, pcs, alu,
                pcw | (pcwc & z), mr | mw, er, st};
    endfunction

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    function automatic logic [23:0] e_if(input logic rdy, input logic z);
        return e(rdy, O, O, I, O, rdy, O, O, O, O, 2'b01, 2'b00, 3'b010, z, O, 4'd0);
    endfunction

    function automatic logic [23:0] e_wb_r(input logic z);
        return e(O, O, O, O, O, O, I, I, O, O, 2'b00, 2'b00, 3'b000, z, O, 4'(S_WB_R));
    endfunction

    // ALU op an R-type funct must select in execute
    function automatic logic [2:0] fn_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b100;
        endcase
    endfunction

    // ---------------- driver-side helpers ----------------
    task automatic add(input string nm, input logic [31:0] ins, input logic rdy,
                       input logic z, input logic r, input logic [23:0] ex);
        step_t s;
        s.inst = ins; s.ready = rdy; s.zero = z; s.rst = r; s.exp = ex; s.name = nm;
        stim_q.push_back(s);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its cycle sequence. Junk is driven on inst
    // wherever the controller must not look at it.
    task automatic run_instr(input logic [31:0] ins, input int if_wait,
                             input int mem_wait, input logic zb, output int ncyc);
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        op = ins[31:26];
        fn = ins[5:0];
        ncyc = 0;
        for (int w = 0; w < if_wait; w++) begin
            z = rb(); add("if_stall", $urandom(), O, z, O, e_if(O, z)); ncyc++;
        end
        z = rb(); add("if", $urandom(), I, z, O, e_if(I, z)); ncyc++;
        z = rb(); add("id", ins, rb(), z, O,
                      e(O, O, O, O, O, O, O, O, O, O, 2'b11, 2'b00, 3'b010, z, O, 4'(S_ID)));
        ncyc++;
        if (op == 6'b100011 || op == 6'b101011) begin
            z = rb(); add("mem_addr", ins, rb(), z, O,
                          e(O, O, O, O, O, O, O, O, O, I, 2'b10, 2'b00, 3'b010, z, O, 4'(S_MEM_ADDR)));
            ncyc++;
            if (op == 6'b100011) begin
                for (int w = 0; w <= mem_wait; w++) begin
                    z = rb();
                    add("mem_rd", $urandom(), (w == mem_wait), z, O,
                        e(O, O, I, I, O, O, O, O, O, O, 2'b00, 2'b00, 3'b000, z, O, 4'(S_MEM_RD)));
                    ncyc++;
                end
                z = rb(); add("wb_lw", $urandom(), rb(), z, O,
                              e(O, O, O, O, O, O, I, O, I, O, 2'b00, 2'b00, 3'b000, z, O, 4'(S_WB_LW)));
                ncyc++;
            end else begin
                for (int w = 0; w <= mem_wait; w++) begin
                    z = rb();
                    add("mem_wr", $urandom(), (w == mem_wait), z, O,
                        e(O, O, I, O, I, O, O, O, O, O, 2'b00, 2'b00, 3'b000, z, O, 4'(S_MEM_WR)));
                    ncyc++;
                end
            end
        end else if (op == 6'b000000) begin
            z = rb(); add("ex_r", ins, rb(), z, O,
                          e(O, O, O, O, O, O, O, O, O, I, 2'b00, 2'b00, fn_alu(fn), z, O, 4'(S_EX_R)));
            z = rb(); add("wb_r", $urandom(), rb(), z, O, e_wb_r(z));
            ncyc += 2;
        end else if (op == 6'b001000 || op == 6'b001010) begin
            z = rb(); add("ex_i", ins, rb(), z, O,
                          e(O, O, O, O, O, O, O, O, O, I, 2'b10, 2'b00,
                            (op == 6'b001010) ? 3'b111 : 3'b010, z, O, 4'(S_EX_I)));
            z = rb(); add("wb_i", $urandom(), rb(), z, O,
                          e(O, O, O, O, O, O, I, O, O, O, 2'b00, 2'b00, 3'b000, z, O, 4'(S_WB_I)));
            ncyc += 2;
        end else if (op == 6'b000100) begin
            add("ex_beq", ins, rb(), zb, O,
                e(O, I, O, O, O, O, O, O, O, I, 2'b00, 2'b01, 3'b110, zb, O, 4'(S_EX_BEQ)));
            ncyc++;
        end else begin
            z = rb(); add("ex_j", ins, rb(), z, O,
                          e(I, O, O, O, O, O, O, O, O, O, 2'b00, 2'b10, 3'b000, z, O, 4'(S_EX_J)));
            ncyc++;
        end
    endtask

    // Illegal instruction: IF, ID, then n sticky ERROR cycles, then one reset cycle.
    task automatic run_err(input logic [31:0] ins, input int n);
        logic z;
        z = rb(); add("if", $urandom(), I, z, O, e_if(I, z));
        z = rb(); add("id_bad", ins, rb(), z, O,
                      e(O, O, O, O, O, O, O, O, O, O, 2'b11, 2'b00, 3'b010, z, O, 4'(S_ID)));
        for (int k = 0; k < n; k++) begin
            z = rb();
            add("error", $urandom(), rb(), z, O,
                e(O, O, O, O, O, O, O, O, O, O, 2'b00, 2'b00, 3'b000, z, I, 4'(S_ERROR)));
        end
        z = rb(); add("err_rst", $urandom(), O, z, I, e_if(O, z));
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // ---------------- compare process ----------------
    logic [23:0] dut_vec;
    assign dut_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                      bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.RegDst,
                      bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
                      bus.ALU_Control, bus.pc_en, bus.CPU_MIO, bus.err, bus.state_out};

    always @(negedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [23:0] ex;
            string       nm;
            ex = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (dut_vec !== ex) begin
                errors++;
                $display("FAIL %s @%0t: got %06h, expected %06h", nm, $time, dut_vec, ex);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        step_t s;
        rst = 1'b1;
        bus.inst = 32'h0;
        bus.MIO_ready = 1'b0;
        bus.zero = 1'b0;

        // model pins
        check_int("pin_if_vec", int'(e_if(I, O)), int'(24'h941160));
        check_int("pin_wb_r_vec", int'(e_wb_r(O)), int'(24'h030007));

        // reset cycles: IF decode with MIO_ready gating
        add("rst_rdy0", 32'h0, O, O, I, e_if(O, O));
        add("rst_rdy1", 32'h0, I, I, I, e_if(I, I));

        run_instr(32'h00221820, 0, 0, O, n); check_int("lat_add", n, 4);
        run_instr(32'h8C220004, 0, 2, O, n); check_int("lat_lw_stall2", n, 7);
        run_instr(32'h10220003, 0, 0, I, n); check_int("lat_beq", n, 3);
        run_instr(32'h10220003, 0, 0, O, n);
        run_instr(32'h08000010, 0, 0, O, n); check_int("lat_j", n, 3);
        run_instr(32'hAC220008, 1, 1, O, n); check_int("lat_sw_stalls", n, 6);
        run_instr(32'h20210005, 2, 0, O, n); check_int("lat_addi_ifstall", n, 6);
        run_instr(32'h28220007, 0, 0, O, n);
        run_instr(32'h00221822, 0, 0, O, n);
        run_instr(32'h00221824, 0, 0, O, n);
        run_instr(32'h00221825, 0, 0, O, n);
        run_instr(32'h0022182A, 0, 0, O, n);
        run_instr(32'h00221827, 0, 0, O, n);
        run_instr(32'h8C220004, 0, 0, O, n); check_int("lat_lw", n, 5);

        run_err(32'hFC000000, 10);
        run_err(32'h00221821, 2);

        // reset in the middle of a stalled store
        begin
            logic z;
            z = rb(); add("if", $urandom(), I, z, O, e_if(I, z));
            add("id_sw", 32'hAC220008, O, z, O,
                e(O, O, O, O, O, O, O, O, O, O, 2'b11, 2'b00, 3'b010, z, O, 4'(S_ID)));
            add("mem_addr_sw", 32'hAC220008, O, z, O,
                e(O, O, O, O, O, O, O, O, O, I, 2'b10, 2'b00, 3'b010, z, O, 4'(S_MEM_ADDR)));
            add("mem_wr_stall", $urandom(), O, z, O,
                e(O, O, I, O, I, O, O, O, O, O, 2'b00, 2'b00, 3'b000, z, O, 4'(S_MEM_WR)));
            add("mem_wr_rst", $urandom(), O, z, I, e_if(O, z));
            add("if_after_rst", $urandom(), O, z, O, e_if(O, z));
        end
        run_instr(32'h00221820, 0, 0, O, n);

        // replay
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            bus.inst      = s.inst;
            bus.MIO_ready = s.ready;
            bus.zero      = s.zero;
            rst           = s.rst;
            exp_q.push_back(s.exp);
            name_q.push_back(s.name);
        end
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 inst  in  32  current IR contents; only [31:26] (op) and [5:0] (funct) are decoded.
REQ-003 zero  in  1  ALU zero flag, valid in EX_BEQ.
REQ-004 MIO_ready  in  1  memory handshake; 1 = access completes this cycle.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA  out  1 each  datapath strobes and 2:1 mux selects.
REQ-006 ALUSrcB  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-007 PCSource  out  2  PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-008 ALU_Control  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor.
REQ-009 pc_en  out  1  PCWrite | (PCWriteCond & zero).
REQ-010 CPU_MIO  out  1  MemRead | MemWrite. err  out  1  illegal instruction. state_out  out  4  current state code.

Function
REQ-011 States SHALL be IF, ID, MEM_ADDR, MEM_RD, WB_LW, MEM_WR, EX_R, WB_R, EX_I, WB_I, EX_BEQ, EX_J, ERROR; state register updates on rising clk.
REQ-012 Outputs SHALL be decoded from the current state, plus funct/op for ALU_Control; unlisted strobes 0, unlisted selects 0.
REQ-013 IF: MemRead=1, ALUSrcB=01, add; IRWrite=PCWrite=MIO_ready; MIO_ready=0 -> stay IF; MIO_ready=1 -> ID.
REQ-014 ID: ALUSrcB=11, add. Next: op 100011/101011 -> MEM_ADDR; 000000 with funct 100000/100010/100100/100101/101010/100111 -> EX_R; 001000/001010 -> EX_I; 000100 -> EX_BEQ; 000010 -> EX_J; else -> ERROR.
REQ-015 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add; lw -> MEM_RD, sw -> MEM_WR.
REQ-016 MEM_RD: IorD=1, MemRead=1; stay until MIO_ready=1, then WB_LW. WB_LW: MemtoReg=1, RegWrite=1 -> IF.
REQ-017 MEM_WR: IorD=1, MemWrite=1; stay until MIO_ready=1, then IF.
REQ-018 EX_R: ALUSrcA=1, ALUSrcB=00, ALU_Control from funct (add/sub/and/or/slt/nor) -> WB_R. WB_R: RegDst=1, RegWrite=1 -> IF.
REQ-019 EX_I: ALUSrcA=1, ALUSrcB=10, add for addi, slt for slti -> WB_I. WB_I: RegDst=0, RegWrite=1 -> IF.
REQ-020 EX_BEQ: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01 -> IF.
REQ-021 EX_J: PCWrite=1, PCSource=10 -> IF.
REQ-022 ERROR: all strobes 0, err=1; sticky until rst.
REQ-023 Latency with MIO_ready=1: R/addi/slti/sw 4 cycles, lw 5, beq/j 3; each MIO_ready=0 cycle in IF/MEM_RD/MEM_WR adds one.
REQ-024 inst SHALL be sampled only in ID and EX states; changes elsewhere have no effect.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IF at any state, including mid-stall and ERROR.
REQ-026 During and after reset, before the first post-reset edge, outputs SHALL equal IF decode with MIO_ready gating; err=0, state_out=IF code (0).

Structure
REQ-027 Package mc_ctrl_pkg SHALL hold state codes, opcode/funct constants, ALU_Control codes, ALUSrcB and PCSource codes.
REQ-028 One sub-module mc_alu_dec SHALL map (state, op, funct) to ALU_Control; the FSM stays in mc_ctrl.

Verification
REQ-029 rst=1, then add $3,$1,$2 (0x00221820), MIO_ready=1 -> IF,ID,EX_R,WB_R; ALU_Control=010 in EX_R; RegDst=1,RegWrite=1 in WB_R; back to IF.
REQ-030 lw (0x8C220004), MIO_ready=0 for 2 cycles in MEM_RD -> MemRead=1,IorD=1 held 3 cycles; WB_LW MemtoReg=1; total 7 cycles.
REQ-031 beq (0x10220003), zero=1 -> pc_en=1 in EX_BEQ, PCSource=01; repeat zero=0 -> pc_en=0.
REQ-032 j (0x08000010) -> EX_J PCWrite=1, PCSource=10; 3 cycles total.
REQ-033 inst=0xFC000000 -> ERROR, err=1, all strobes 0 for 10 cycles; rst=1 -> IF, err=0.
REQ-034 rst asserted during MEM_WR stall -> next state IF, MemWrite=0.
